// File: rtl/axi_delay_fifo.sv
// AXI-Stream FIFO with a programmable sample delay and a tlast side channel.
// A delay increase injects zero words into the stream. A delay decrease discards
// accepted input beats. The RAM feeds a two-stage output pipeline (d0 -> d1), so an
// empty FIFO has a 3-cycle write-to-valid latency. The FIFO holds DEPTH + 2 words.
module axi_delay_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DELAY_WIDTH  = 8,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  almost_full,
    output logic                  delay_busy
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int WW    = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AFULL_VAL = (ADDR_WIDTH+1)'(AFULL_THRESH);

    typedef enum logic [1:0] {ST_IDLE, ST_INSERT, ST_DROP} state_t;

    // Storage: each word is {tlast, tdata}
    logic [WW-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]  occ_q, occ_d;
    logic                 afull_q;
    logic                 empty, full;
    logic                 wr_en, rd_en, d1_load;
    logic [WW-1:0]        wr_word;
    logic                 s_ready_c;

    logic                 d0_valid_q, d1_valid_q;
    logic [WW-1:0]        d0_word_q, d1_word_q;

    state_t               state_q;
    logic [DELAY_WIDTH-1:0] applied_q, target_q, count_q;
    logic                 busy_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    // Write side: what gets written and whether the upstream is ready, per FSM state
    always_comb begin
        wr_en     = 1'b0;
        wr_word   = {s_axis_tlast, s_axis_tdata};
        s_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready_c = ~full;
                wr_en     = s_axis_tvalid & ~full;
            end
            ST_INSERT: begin
                wr_en   = ~full;
                wr_word = '0;
            end
            ST_DROP: begin
                // beats are accepted and discarded; nothing reaches the RAM
                s_ready_c = 1'b1;
            end
            default: begin
                s_ready_c = 1'b0;
            end
        endcase
    end

    // Read side: pull from RAM whenever the two-stage pipeline can absorb a word
    always_comb begin
        d1_load  = m_axis_tready | ~d1_valid_q;
        rd_en    = ~empty & (~(d0_valid_q & d1_valid_q) | m_axis_tready);
        wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(rd_en);
        occ_d    = wr_ptr_d - rd_ptr_d;
    end

    // RAM write port (contents intentionally not cleared by reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

    // Pointers and registered status reflecting this cycle's pointer updates
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            afull_q  <= (occ_d >= AFULL_VAL);
        end
    end

    // Output pipeline: d0 captures the RAM read, d1 drives m_axis and holds while stalled
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            d0_valid_q <= 1'b0;
            d0_word_q  <= '0;
            d1_valid_q <= 1'b0;
            d1_word_q  <= '0;
        end else begin
            if (d1_load) begin
                d1_valid_q <= d0_valid_q;
                if (d0_valid_q) begin
                    d1_word_q <= d0_word_q;
                end
            end
            if (rd_en) begin
                d0_valid_q <= 1'b1;
                d0_word_q  <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            end else if (d1_load) begin
                d0_valid_q <= 1'b0;
            end
        end
    end

    // Delay-change FSM: IDLE compares the requested delay with the applied one
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q   <= ST_IDLE;
            applied_q <= '0;
            target_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (delay > applied_q) begin
                        target_q <= delay;
                        count_q  <= delay - applied_q;
                        state_q  <= ST_INSERT;
                        busy_q   <= 1'b1;
                    end else if (delay < applied_q) begin
                        target_q <= delay;
                        count_q  <= applied_q - delay;
                        state_q  <= ST_DROP;
                        busy_q   <= 1'b1;
                    end
                end
                ST_INSERT: begin
                    if (!full) begin
                        count_q <= count_q - DELAY_WIDTH'(1);
                        if (count_q == DELAY_WIDTH'(1)) begin
                            applied_q <= target_q;
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid) begin
                        count_q <= count_q - DELAY_WIDTH'(1);
                        if (count_q == DELAY_WIDTH'(1)) begin
                            applied_q <= target_q;
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = s_ready_c;
    assign m_axis_tvalid = d1_valid_q;
    assign m_axis_tdata  = d1_word_q[DATA_WIDTH-1:0];
    assign m_axis_tlast  = d1_word_q[DATA_WIDTH];
    assign occupancy     = occ_q;
    assign almost_full   = afull_q;
    assign delay_busy    = busy_q;

endmodule
